// File: rtl/pipeline_controller.sv
// Central sequencer for the 5-stage MIPS pipeline: debug run/step/halt FSM, hazard stalls, branch flushes, HALT drain.
// Optional macro STALL_COUNTER_EN adds o_stall_count (saturating count of load-use stall cycles).
module pipeline_controller #(
    parameter int REG_ADDRS_BITS = 5,
    parameter int CYCLE_CNT_BITS = 32,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic                      i_step,
    input  logic                      i_halt_instr,
    input  logic [REG_ADDRS_BITS-1:0] i_if_id_rs,
    input  logic [REG_ADDRS_BITS-1:0] i_if_id_rt,
    input  logic                      i_id_ex_MemRead,
    input  logic [REG_ADDRS_BITS-1:0] i_id_ex_rt,
    input  logic                      i_taken,
    output logic                      o_pc_enable,
    output logic                      o_if_id_enable,
    output logic                      o_if_id_flush,
    output logic                      o_id_ex_flush,
    output logic                      o_back_enable,
    output logic                      o_halted,
`ifdef STALL_COUNTER_EN
    output logic [CYCLE_CNT_BITS-1:0] o_cycle_count,
    output logic [CYCLE_CNT_BITS-1:0] o_stall_count
`else
    output logic [CYCLE_CNT_BITS-1:0] o_cycle_count
`endif
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 load_use;
    logic                 active;

    // A load into $zero never produces a value, so it can never cause a hazard.
    assign load_use = i_id_ex_MemRead && (i_id_ex_rt != '0) &&
                      ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

    assign active = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_back_enable  = 1'b0;
        o_halted       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start)     state_d = S_RUN;
                else if (i_step) state_d = S_STEP;
            end
            S_RUN, S_STEP: begin
                o_back_enable = 1'b1;
                if (state_q == S_STEP) state_d = S_IDLE;
                // A taken branch squashes the ID instruction, so its stall/HALT no longer matters.
                if (i_taken) begin
                    o_pc_enable    = 1'b1;
                    o_if_id_enable = 1'b1;
                    o_if_id_flush  = 1'b1;
                    o_id_ex_flush  = 1'b1;
                end else if (load_use) begin
                    o_id_ex_flush = 1'b1;
                end else if (i_halt_instr) begin
                    o_id_ex_flush = 1'b1;
                    state_d       = S_DRAIN;
                    drain_d       = DRAIN_LOAD;
                end else begin
                    o_pc_enable    = 1'b1;
                    o_if_id_enable = 1'b1;
                end
            end
            S_DRAIN: begin
                o_id_ex_flush = 1'b1;
                o_back_enable = 1'b1;
                if (drain_q == '0) state_d = S_HALTED;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            S_HALTED: begin
                o_halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            o_cycle_count <= '0;
        else if (active && (o_cycle_count != '1))
            o_cycle_count <= o_cycle_count + CYCLE_CNT_BITS'(1);
    end

`ifdef STALL_COUNTER_EN
    logic stall_apply;

    assign stall_apply = ((state_q == S_RUN) || (state_q == S_STEP)) && !i_taken && load_use;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            o_stall_count <= '0;
        else if (stall_apply && (o_stall_count != '1))
            o_stall_count <= o_stall_count + CYCLE_CNT_BITS'(1);
    end
`endif

endmodule
